instr_fetch_unit: RTL
=====================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, address/data width matching the instruction ROM.
REQ-002 SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port stall  input  1  downstream cannot accept a new instruction; hold PC and ROM output.
REQ-006 SHALL have port redirect_valid  input  1  branch/jump taken; load redirect_pc.
REQ-007 SHALL have port redirect_pc  input  WIDTH  redirect target byte address.
REQ-008 SHALL have port halt_req  input  1  request to stop fetching.
REQ-009 SHALL have port resume  input  1  request to restart fetching from HALT.
REQ-010 SHALL have port rom_addr  output  WIDTH  byte address to instruction ROM port A.
REQ-011 SHALL have port rom_en  output  1  ROM port A read enable.
REQ-012 SHALL have port rom_flush  output  1  ROM port A synchronous clear of read data (inserts NOP).
REQ-013 SHALL have port fetch_pc  output  WIDTH  PC of the instruction currently on ROM read data.
REQ-014 SHALL have port fetch_valid  output  1  ROM read data holds a real (non-flushed) instruction.
REQ-015 SHALL have port fetch_count  output  WIDTH  number of instructions fetched since reset.

Function
REQ-016 SHALL hold a PC register; rom_addr SHALL equal PC combinationally, PC[1:0] always 0.
REQ-017 SHALL implement FSM states BOOT, RUN, HALT, encoded in 2 bits.
REQ-018 BOOT SHALL last exactly one cycle after rst deasserts, then go to RUN; in BOOT rom_en=0 and rom_flush=1.
REQ-019 RUN SHALL go to HALT when halt_req=1 and redirect_valid=0; HALT SHALL go to RUN when resume=1.
REQ-020 halt_req and resume both high in HALT SHALL resolve to RUN; both high in RUN SHALL resolve to HALT.
REQ-021 In RUN, rom_en SHALL be 1 when stall=0 and 0 when stall=1; in HALT rom_en=0 and rom_flush=1.
REQ-022 ROM read latency is one cycle; an address presented with rom_en=1 in cycle N SHALL appear on ROM data in cycle N+1 with fetch_pc=that address.
REQ-023 In RUN with stall=0 and no redirect, PC SHALL advance by 4, wrapping modulo 2^WIDTH.
REQ-024 With stall=1 and no redirect, PC, fetch_pc, fetch_valid and fetch_count SHALL hold.
REQ-025 redirect_valid=1 SHALL take priority over stall and halt_req: PC <= {redirect_pc[WIDTH-1:2],2'b00}, rom_flush=1 and rom_en=0 that cycle.
REQ-026 redirect_valid=1 in HALT SHALL update PC and keep state HALT; in BOOT it SHALL update PC and proceed to RUN.
REQ-027 When rom_flush=1, fetch_valid SHALL clear to 0 and fetch_pc SHALL clear to 0 next cycle.
REQ-028 When rom_en=1 and rom_flush=0, fetch_pc <= PC, fetch_valid <= 1, fetch_count <= fetch_count+1 (wraps).
REQ-029 rom_en and rom_flush SHALL never both be 1 in the same cycle.

Reset
REQ-030 rst=1 SHALL force state BOOT, PC=RESET_PC, fetch_pc=0, fetch_valid=0, fetch_count=0 at the next edge, overriding all other inputs.
REQ-031 While rst=1, rom_en SHALL be 0 and rom_flush SHALL be 1.
REQ-032 rst asserted mid-run SHALL abandon any pending redirect, stall or halt with no residual effect.

Verification
REQ-033 Reset then 5 free cycles, RESET_PC=0 -> rom_addr 0,0,4,8,12; fetch_valid first 1 in cycle 3 with fetch_pc=0; fetch_count=3 after cycle 5.
REQ-034 In RUN at PC=0x10, stall=1 for 3 cycles -> rom_addr stays 0x10, rom_en=0, fetch_pc/fetch_count unchanged; release -> 0x14 next.
REQ-035 At PC=0x20, redirect_valid=1, redirect_pc=0x103, stall=1 -> next PC=0x100, fetch_valid=0 one cycle, then fetch_pc=0x100 valid.
REQ-036 halt_req at PC=0x30 -> HALT, rom_flush=1, fetch_valid=0; redirect 0x40 in HALT stays HALT; resume -> first fetch_pc=0x40.
REQ-037 PC=0xFFFFFFFC, no stall -> next rom_addr=0x00000000, fetch_pc=0xFFFFFFFC valid.
REQ-038 rst pulsed during stall with pending halt_req -> BOOT, PC=RESET_PC, fetch_count=0, then normal RUN sequence.

Source files
------------

// File: rtl/instr_fetch_unit.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Purpose:
//   Instruction fetch front end for a synchronous-read instruction ROM.
//   It keeps the program counter and drives ROM port A. It also tracks which
//   PC the ROM read data belongs to, whether that data is a real instruction
//   or a flushed bubble, and how many instructions have been fetched.
//   A small BOOT/RUN/HALT state machine sequences start-up and halting.
//
// Handshake / timing contract:
//   The ROM has a one-cycle read latency. An address presented on rom_addr
//   with rom_en=1 in cycle N is on ROM read data in cycle N+1. In that same
//   cycle fetch_pc/fetch_valid describe it. rom_flush=1 in cycle N makes the
//   ROM clear its read data at the edge, so cycle N+1 carries a bubble
//   (fetch_valid=0, fetch_pc=0). rom_en and rom_flush are mutually exclusive
//   by construction. stall=1 means downstream did not take the current
//   instruction: no new read is issued and all fetch state holds.
//
// Ports:
//   clk            in   clock, all state updates on the rising edge
//   rst            in   synchronous active-high reset
//   stall          in   downstream back-pressure; hold PC and ROM output
//   redirect_valid in   taken branch/jump; load redirect_pc (word aligned)
//   redirect_pc    in   redirect target byte address
//   halt_req       in   request to stop fetching
//   resume         in   request to restart fetching from HALT
//   rom_addr       out  byte address to ROM port A (equals PC)
//   rom_en         out  ROM port A read enable
//   rom_flush      out  ROM port A synchronous clear of read data (NOP)
//   fetch_pc       out  PC of the instruction currently on ROM read data
//   fetch_valid    out  ROM read data is a real instruction
//   fetch_count    out  instructions fetched since reset (wraps)
//   dbg_state      out  current FSM state (BOOT=0, RUN=1, HALT=2)
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic             halt_req,
    input  logic             resume,
    output logic [WIDTH-1:0] rom_addr,
    output logic             rom_en,
    output logic             rom_flush,
    output logic [WIDTH-1:0] fetch_pc,
    output logic             fetch_valid,
    output logic [WIDTH-1:0] fetch_count,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] PC_STEP          = WIDTH'(4);
    localparam logic [WIDTH-1:0] COUNT_ONE        = WIDTH'(1);
    localparam logic [WIDTH-1:0] RESET_PC_ALIGNED = {RESET_PC[WIDTH-1:2], 2'b00};

    state_t           state;
    logic [WIDTH-1:0] pc;

    assign rom_addr  = pc;
    assign dbg_state = state;

    // Port A controls have to react to stall/redirect/rst in the same cycle,
    // so they are decoded from the registered state rather than registered.
    // Any cycle that is not a clean RUN cycle inserts a bubble; a clean RUN
    // cycle reads unless stalled. This makes en/flush exclusive by design.
    always_comb begin
        rom_en    = 1'b0;
        rom_flush = 1'b0;
        if (rst || redirect_valid || (state != RUN)) begin
            rom_flush = 1'b1;
        end else begin
            rom_en = !stall;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= BOOT;
            pc          <= RESET_PC_ALIGNED;
            fetch_pc    <= '0;
            fetch_valid <= 1'b0;
            fetch_count <= '0;
        end else begin
            // Track what the ROM will present next cycle.
            if (rom_flush) begin
                fetch_pc    <= '0;
                fetch_valid <= 1'b0;
            end else if (rom_en) begin
                fetch_pc    <= pc;
                fetch_valid <= 1'b1;
                fetch_count <= fetch_count + COUNT_ONE;
            end

            // Redirect wins over everything; otherwise advance only when a
            // read was actually issued this cycle.
            if (redirect_valid) begin
                pc <= {redirect_pc[WIDTH-1:2], 2'b00};
            end else if (rom_en) begin
                pc <= pc + PC_STEP;
            end

            case (state)
                BOOT: state <= RUN;
                RUN: begin
                    if (halt_req && !redirect_valid) begin
                        state <= HALT;
                    end
                end
                HALT: begin
                    // A redirect while halted only retargets the PC.
                    if (resume && !redirect_valid) begin
                        state <= RUN;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

endmodule
